// File: rtl/pipe_pkg.sv
// Shared constants for the pipeline stage register: state encoding,
// the ID/EX bubble payload and the ID/EX field offsets.
package pipe_pkg;

    // Stage state; the encoding equals the number of entries held.
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_TWO   = 2'd2;

    // ID/EX payload packing (bit offsets of the least significant bit).
    localparam int IDEX_W          = 128;
    localparam int IDEX_OP_LSB     = 0;    // 7-bit opcode
    localparam int IDEX_RD_LSB     = 7;    // 5-bit destination register
    localparam int IDEX_FUNCT3_LSB = 12;   // 3-bit funct3
    localparam int IDEX_RS1_LSB    = 15;   // 5-bit source register 1
    localparam int IDEX_RS2_LSB    = 20;   // 5-bit source register 2
    localparam int IDEX_FUNCT7_LSB = 25;   // 7-bit funct7
    localparam int IDEX_IMM_LSB    = 32;   // 32-bit immediate
    localparam int IDEX_PC_LSB     = 64;   // 32-bit program counter
    localparam int IDEX_RSV_LSB    = 96;   // 32 bits reserved, kept zero

    // ADDI x0, x0, 0: opcode OP-IMM, every other field zero.
    localparam logic [6:0]        IDEX_OP_NOP = 7'b0010011;
    localparam logic [IDEX_W-1:0] IDEX_NOP    = {{(IDEX_W-7){1'b0}}, IDEX_OP_NOP};

endpackage

// File: rtl/pipe_skid_stage_if.sv
// One valid/ready/data channel. The master drives valid and data and
// observes ready; the slave observes valid and data and drives ready.
interface pipe_skid_stage_if #(
    parameter int DATA_W = 128
);
    logic              valid;
    logic              ready;
    logic [DATA_W-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/sat_counter.sv
// Counter that adds 0, 1 or 2 per cycle and sticks at all-ones.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [1:0]   i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;
    logic [W:0]   w_sum;

    // One extra bit catches the carry out so saturation needs no compare.
    always_comb begin
        w_sum = {1'b0, r_cnt} + {{(W-1){1'b0}}, i_inc};
    end

    // Accumulate, clamping at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_sum[W]) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_sum[W-1:0];
        end
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/pipe_skid_stage.sv
// Pipeline stage register with a one-entry skid buffer. All outputs come
// from registers, so neither the forward data path nor the backward ready
// path passes combinationally through the stage.
module pipe_skid_stage
    import pipe_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter logic [DATA_W-1:0] NOP_VALUE = '0,
    parameter int                CNT_W     = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    pipe_skid_stage_if.slave   up,
    pipe_skid_stage_if.master  dn,
    output logic [1:0]         occupancy,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   drop_cnt
);
    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main;
    logic [DATA_W-1:0] r_skid;

    logic              w_in_xfer;
    logic              w_out_xfer;
    logic [1:0]        w_stall_inc;
    logic [1:0]        w_drop_inc;

    // Handshake decisions and counter increments for this cycle.
    // NOTE: every signal gets a default before any if, so no latch is inferred.
    always_comb begin
        w_in_xfer   = up.valid && (r_state != ST_TWO);
        w_out_xfer  = (r_state != ST_EMPTY) && dn.ready;
        w_stall_inc = 2'd0;
        w_drop_inc  = 2'd0;
        if (!flush && (r_state != ST_EMPTY) && !dn.ready) begin
            w_stall_inc = 2'd1;
        end
        // Entries held but not consumed, plus the one offered and accepted.
        if (flush) begin
            w_drop_inc = r_state - {1'b0, w_out_xfer} + {1'b0, w_in_xfer};
        end
    end

    // State and head register; flush turns the stage into a bubble.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_state <= ST_EMPTY;
            r_main  <= NOP_VALUE;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        r_main  <= up.data;
                        r_state <= ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        r_main <= up.data;
                    end else if (w_in_xfer) begin
                        r_state <= ST_TWO;
                    end else if (w_out_xfer) begin
                        r_main  <= NOP_VALUE;
                        r_state <= ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (w_out_xfer) begin
                        r_main  <= r_skid;
                        r_state <= ST_ONE;
                    end
                end
                default: begin
                    // Unreachable encoding: recover to a clean bubble.
                    r_main  <= NOP_VALUE;
                    r_state <= ST_EMPTY;
                end
            endcase
        end
    end

    // Skid register captures the second entry while the head is stalled.
    // NOTE: the skid is deliberately not reset; its contents only matter in
    // ST_TWO, which is always entered by writing it.
    always_ff @(posedge clk) begin
        if (!rst && !flush && (r_state == ST_ONE) && w_in_xfer && !w_out_xfer) begin
            r_skid <= up.data;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_stall_inc),
        .o_cnt (stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .i_inc (w_drop_inc),
        .o_cnt (drop_cnt)
    );

    assign up.ready  = (r_state != ST_TWO);
    assign dn.valid  = (r_state != ST_EMPTY);
    assign dn.data   = r_main;
    assign occupancy = r_state;
endmodule
